// File: rtl/packing_shift_register.sv
// packing_shift_register
//   Serial-in / parallel-out word packer. Collects NUM_WORDS words of IN_W bits
//   through a valid/ready handshake and presents them as one OUT_W-bit vector
//   with its own valid/ready handshake. A partial vector can be closed early
//   with flush; the unfilled slots read as zero.
//
// Parameters
//   IN_W       width of one input word (>=1)
//   NUM_WORDS  words per packed vector (>=2), OUT_W = IN_W*NUM_WORDS
//   MSB_FIRST  1: first word lands in the top slot, 0: first word lands in slot 0
//
// Ports
//   clock      rising-edge clock
//   rst        asynchronous reset, active-high
//   clear      synchronous clear: empties the buffer and drops any vector
//   flush      closes a partial vector, zero-padding the remaining slots
//   in_valid   in_data is valid
//   in_ready   the block accepts a word this cycle
//   in_data    input word
//   out_valid  packed vector available
//   out_ready  consumer takes the vector this cycle
//   out_data   packed vector
//   out_count  number of real (non-pad) words in out_data
//   level      words collected into the vector currently being built

module packing_shift_register #(
  parameter int IN_W      = 8,
  parameter int NUM_WORDS = 16,
  parameter bit MSB_FIRST = 1'b1,
  localparam int OUT_W    = IN_W * NUM_WORDS,
  localparam int CNT_W    = $clog2(NUM_WORDS + 1)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clear,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] level
);

  localparam logic [CNT_W-1:0] NUM_WORDS_C = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C      = {CNT_W{1'b0}};
  localparam logic [OUT_W-1:0] ZERO_VEC_C  = {OUT_W{1'b0}};

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [OUT_W-1:0]   data_r;
  logic [OUT_W-1:0]   data_s;
  logic [CNT_W-1:0]   level_r;
  logic [CNT_W-1:0]   level_s;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_s;
  logic [OUT_W-1:0]   packed_s;
  logic [CNT_W-1:0]   fill_m_s;
  logic               in_ready_s;
  logic               in_xfer_s;
  logic               out_xfer_s;

  // Shift the packing register by one slot and insert the new word at the
  // entry slot. After NUM_WORDS insertions the first word sits in its final
  // slot, so a complete vector needs no further alignment.
  function automatic logic [OUT_W-1:0] insert_word(input logic [OUT_W-1:0] vec,
                                                   input logic [IN_W-1:0]  word);
    logic [OUT_W-1:0] res;
    if (MSB_FIRST) begin
      res = {vec[OUT_W-IN_W-1:0], word};
    end else begin
      res = {word, vec[OUT_W-1:IN_W]};
    end
    return res;
  endfunction

  // A partial vector of m words sits at the entry end of the register; move it
  // by the number of missing slots so word 0 reaches its final slot. Zeros
  // shift in behind it and form the padding.
  function automatic logic [OUT_W-1:0] align_partial(input logic [OUT_W-1:0] vec,
                                                     input logic [CNT_W-1:0] m);
    logic [CNT_W-1:0] pad_slots;
    logic [31:0]      shamt;
    logic [OUT_W-1:0] res;
    pad_slots = NUM_WORDS_C - m;
    shamt     = 32'(pad_slots) * 32'(IN_W);
    if (MSB_FIRST) begin
      res = vec << shamt;
    end else begin
      res = vec >> shamt;
    end
    return res;
  endfunction

  // Handshake qualifiers: while a vector is held, input is accepted only when
  // that vector leaves at the same edge.
  always_comb begin
    in_ready_s = (state_r == ST_FILL) | out_ready;
    in_xfer_s  = in_valid & in_ready_s;
    out_xfer_s = (state_r == ST_FULL) & out_ready;
  end

  // Next-state, packing-register and counter logic.
  always_comb begin
    state_s  = state_r;
    data_s   = data_r;
    level_s  = level_r;
    count_s  = count_r;
    packed_s = data_r;
    fill_m_s = level_r;
    if (clear) begin
      state_s = ST_FILL;
      data_s  = ZERO_VEC_C;
      level_s = ZERO_C;
      count_s = ZERO_C;
    end else begin
      case (state_r)
        ST_FILL: begin
          // packed_s / fill_m_s include a word accepted in this same cycle,
          // so a flush closes the vector with that word in it.
          if (in_xfer_s) begin
            packed_s = insert_word(data_r, in_data);
            fill_m_s = level_r + ONE_C;
          end else begin
            packed_s = data_r;
            fill_m_s = level_r;
          end
          if (fill_m_s == NUM_WORDS_C) begin
            state_s = ST_FULL;
            data_s  = packed_s;
            count_s = NUM_WORDS_C;
            level_s = ZERO_C;
          end else if (flush && (fill_m_s != ZERO_C)) begin
            state_s = ST_FULL;
            data_s  = align_partial(packed_s, fill_m_s);
            count_s = fill_m_s;
            level_s = ZERO_C;
          end else begin
            data_s  = packed_s;
            level_s = fill_m_s;
          end
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            // The vector leaves; a word arriving at the same edge starts the
            // next vector so a held-high out_ready sustains one word per clock.
            state_s = ST_FILL;
            if (in_xfer_s) begin
              data_s  = insert_word(ZERO_VEC_C, in_data);
              level_s = ONE_C;
            end else begin
              data_s  = ZERO_VEC_C;
              level_s = ZERO_C;
            end
          end else begin
            state_s = ST_FULL;
            data_s  = data_r;
            level_s = level_r;
          end
        end
        default: begin
          state_s = ST_FILL;
          data_s  = ZERO_VEC_C;
          level_s = ZERO_C;
          count_s = ZERO_C;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r <= ST_FILL;
      data_r  <= ZERO_VEC_C;
      level_r <= ZERO_C;
      count_r <= ZERO_C;
    end else begin
      state_r <= state_s;
      data_r  <= data_s;
      level_r <= level_s;
      count_r <= count_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == ST_FULL);
  assign out_data  = data_r;
  assign out_count = count_r;
  assign level     = level_r;

endmodule
